mult_datapath: RTL and testbench
================================

Name: mult_datapath

Overview:
- Shift-add multiplier datapath; sits directly downstream of the multiplier control unit.
- Consumes the control unit's wrctrl/addctrl/srtctrl/ready strobes.
- Returns the current multiplier LSB, which drives the controller's add/skip decision.
- Latches operands, performs one conditional-add plus right-shift per shift cycle, and captures the final product with a valid pulse and a protocol-error flag.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- load  input  1  latch operands, clear accumulator and shift counter.
- multiplicand  input  WIDTH  operand A, sampled when load=1.
- multiplier  input  WIDTH  operand B, sampled when load=1.
- wrctrl  input  1  write the adder result into the accumulator upper half.
- addctrl  input  1  select multiplicand (1) or zero (0) as the adder B input.
- srtctrl  input  1  shift the accumulator right by one.
- ready  input  1  controller completion level; its rising edge triggers result capture.
- lsb  output  1  accumulator bit 0, combinational from the register.
- product  output  2*WIDTH  captured result, held until the next capture.
- product_valid  output  1  one-cycle pulse on capture.
- err  output  1  sticky: capture occurred with shift count != WIDTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all registers clear; lsb=0, product=0, product_valid=0, err=0.
- Priority per edge: rst > load > datapath op. Capture evaluates independently of load/op in the same cycle.
- Registers:
  - M, WIDTH bits: multiplicand.
  - A, 2*WIDTH+1 bits: carry bit, upper half, lower half.
  - cnt: shift counter, saturating at WIDTH+1.
  - ready_q: previous ready.
- load=1: M<=multiplicand; A<={1'b0, WIDTH zeros, multiplier}; cnt<=0. Any op strobes that cycle are ignored.
- sum = {1'b0, A upper half} + (addctrl ? M : 0), WIDTH+1 bits; carry is kept.
- Datapath op, when load=0:
  - wrctrl=1, srtctrl=1: A <= {sum, A lower half} >> 1 (shift in 0 at MSB); cnt<=cnt+1 (saturating).
  - wrctrl=0, srtctrl=1: A <= {1'b0, A[2W:1]}; cnt increments.
  - wrctrl=1, srtctrl=0: A upper+carry <= sum; no shift; cnt unchanged.
  - both 0: hold.
- lsb = A[0]. The updated value is visible the cycle after an op, matching the controller's one-decision-per-cycle use.
- Capture:
  - Condition: ready=1 and ready_q=0.
  - Actions: product<=A[2W-1:0]; product_valid<=1 for exactly one cycle; err<=err | (cnt!=WIDTH).
  - Level-held ready does not recapture.
  - If load coincides with capture, capture uses pre-load A and cnt.
- Completed result: after WIDTH shift cycles, A[2W-1:0] equals multiplicand*multiplier exactly. The carry bit absorbs upper-half overflow before each shift; no truncation.
- Boundary conditions:
  - Shifting past WIDTH continues the arithmetic. cnt saturates at WIDTH+1, so a late capture flags err.
  - load mid-operation aborts cleanly. Prior product and product_valid are unaffected.
  - rst mid-operation clears everything, including err and held product.
  - err clears only on rst.
- Size: 120-250 lines of RTL.

Test Plan:
- rst; load 3, 5; drive 32 shift cycles, with wrctrl=addctrl=lsb each cycle; raise ready -> product=0x0000_0000_0000_000F, one-cycle product_valid, err=0.
- Load 0xFFFFFFFF, 0xFFFFFFFF; 32 add-shifts -> product=0xFFFFFFFE_00000001; carry path exercised; err=0.
- Load 0, 0x12345678; 32 cycles -> product=0, lsb sequence follows multiplier bits LSB-first: 0,0,0,1,1,1,1,0...
- Load 7, 9; after 10 cycles assert load with 2, 4; 32 cycles -> product=8. Earlier product unchanged until the new capture.
- Ready rising after only 31 shifts -> product_valid pulses, err=1 and stays 1 across later correct runs until rst. Ready held high 5 cycles -> single pulse.
- rst asserted mid-run, cycle 16 -> next cycle product=0, product_valid=0, err=0, lsb=0.

Source files
------------

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: holds the operands and accumulator, does one conditional add
// plus right shift per controller strobe, and captures the product on the rising edge of ready.
module mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 wrctrl,
    input  logic                 addctrl,
    input  logic                 srtctrl,
    input  logic                 ready,
    output logic                 lsb,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH:0]   r_a;
    logic [CW-1:0]      r_cnt;
    logic               r_ready_q;
    logic [2*WIDTH-1:0] r_product;
    logic               r_product_valid;
    logic               r_err;

    logic [WIDTH:0]     w_sum;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_capture;

    // Adder keeps its carry so the upper half never overflows before the shift.
    assign w_sum     = {1'b0, r_a[2*WIDTH-1:WIDTH]} + {1'b0, (addctrl ? r_m : '0)};
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    assign w_capture = ready & ~r_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_a   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_m   <= multiplicand;
            r_a   <= {1'b0, {WIDTH{1'b0}}, multiplier};
            r_cnt <= '0;
        end else begin
            unique case ({wrctrl, srtctrl})
                2'b11: begin
                    r_a   <= {1'b0, w_sum, r_a[WIDTH-1:1]};
                    r_cnt <= w_cnt_inc;
                end
                2'b01: begin
                    r_a   <= {1'b0, r_a[2*WIDTH:1]};
                    r_cnt <= w_cnt_inc;
                end
                2'b10: r_a <= {w_sum, r_a[WIDTH-1:0]};
                default: ;
            endcase
        end
    end

    // Capture sees the pre-load accumulator and count, independent of load/op this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_q       <= 1'b0;
            r_product       <= '0;
            r_product_valid <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_ready_q       <= ready;
            r_product_valid <= w_capture;
            if (w_capture) begin
                r_product <= r_a[2*WIDTH-1:0];
                r_err     <= r_err | (r_cnt != CNT_DONE);
            end
        end
    end

    assign lsb           = r_a[0];
    assign product       = r_product;
    assign product_valid = r_product_valid;
    assign err           = r_err;

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: acts as the shift-add controller and compares the captured product,
// lsb sequence, valid pulse and sticky error against a plain arithmetic model.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        rst, load, wrctrl, addctrl, srtctrl, ready;
    logic [31:0] multiplicand, multiplier;
    logic        lsb, product_valid, err;
    logic [63:0] product;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_prod;

    mult_datapath #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load(load),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .wrctrl(wrctrl), .addctrl(addctrl), .srtctrl(srtctrl), .ready(ready),
        .lsb(lsb), .product(product), .product_valid(product_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        load = 1'b0; wrctrl = 1'b0; addctrl = 1'b0; srtctrl = 1'b0; ready = 1'b0;
    endtask

    // Load, perform nshift controller-driven shift cycles, then raise ready for 'hold' cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int nshift,
                          input int hold, input logic exp_err, input logic chk_prod,
                          input string name);
        logic [63:0] exp_p;
        int          pulses;
        exp_p = 64'(a) * 64'(b);
        @(negedge clk);
        idle_inputs();
        load = 1'b1; multiplicand = a; multiplier = b;
        for (int k = 0; k < nshift; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (k < 32) begin
                checks++;
                if (lsb !== b[k]) begin
                    errors++;
                    $display("FAIL %s_lsb[%0d]: got %0b expected %0b", name, k, lsb, b[k]);
                end
            end
            srtctrl = 1'b1; wrctrl = lsb; addctrl = lsb;
        end
        @(negedge clk);
        idle_inputs();
        ready = 1'b1;
        pulses = 0;
        for (int h = 0; h < hold + 2; h++) begin
            @(negedge clk);
            if (product_valid === 1'b1) pulses++;
            checks++;
            if (product_valid !== (h == 0)) begin
                errors++;
                $display("FAIL %s_valid[%0d]: got %0b expected %0b", name, h, product_valid, (h == 0));
            end
            if (h == 0) begin
                checks++;
                if (err !== exp_err) begin
                    errors++;
                    $display("FAIL %s_err: got %0b expected %0b", name, err, exp_err);
                end
                if (chk_prod) begin
                    checks++;
                    if (product !== exp_p) begin
                        errors++;
                        $display("FAIL %s_product: got %h expected %h", name, product, exp_p);
                    end
                end
                last_prod = product;
            end
            if (h == hold - 1) ready = 1'b0;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s_pulses: got %0d expected 1", name, pulses);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        multiplicand = '0; multiplier = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({lsb, product_valid, err} !== 3'b000 || product !== 64'd0) begin
            errors++;
            $display("FAIL reset: got lsb=%0b valid=%0b err=%0b product=%h expected all zero",
                     lsb, product_valid, err, product);
        end
    endtask

    task automatic test_directed();
        run_op(32'd3, 32'd5, 32, 1, 1'b0, 1'b1, "mul_3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 1, 1'b0, 1'b1, "mul_max");
        run_op(32'd0, 32'h1234_5678, 32, 1, 1'b0, 1'b1, "mul_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_op($urandom, $urandom, 32, 1, 1'b0, 1'b1, $sformatf("rand%0d", i));
    endtask

    task automatic test_load_abort();
        logic [63:0] prev;
        prev = last_prod;
        @(negedge clk);
        idle_inputs();
        load = 1'b1; multiplicand = 32'd7; multiplier = 32'd9;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            load = 1'b0;
            srtctrl = 1'b1; wrctrl = lsb; addctrl = lsb;
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (product !== prev || product_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: got product=%h valid=%0b expected %h valid=0",
                     product, product_valid, prev);
        end
        run_op(32'd2, 32'd4, 32, 1, 1'b0, 1'b1, "abort_2x4");
    endtask

    task automatic test_err_sticky();
        run_op(32'd11, 32'd13, 31, 1, 1'b1, 1'b0, "short_run");
        run_op(32'd6, 32'd7, 32, 5, 1'b1, 1'b1, "held_ready");
        run_op($urandom, $urandom, 33, 1, 1'b1, 1'b0, "long_run");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        idle_inputs();
        load = 1'b1; multiplicand = 32'hDEAD_BEEF; multiplier = 32'h0BAD_F00D;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            load = 1'b0;
            srtctrl = 1'b1; wrctrl = lsb; addctrl = lsb;
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({lsb, product_valid, err} !== 3'b000 || product !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset: got lsb=%0b valid=%0b err=%0b product=%h expected all zero",
                     lsb, product_valid, err, product);
        end
        run_op(32'd3, 32'd5, 32, 1, 1'b0, 1'b1, "after_reset");
    endtask

    initial begin
        last_prod = '0;
        test_reset();
        test_directed();
        test_random();
        test_load_abort();
        test_err_sticky();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
